cook_sequencer: RTL and testbench
=================================

# cook_sequencer

Top-level microwave cook controller that sequences the magnetron path. It collects a BCD cook time from the keypad and runs a one-second-resolution MM:SS countdown. It decides when the magnetron may run, and handles pause, resume, clear and door-open conditions. It replaces free-running button/latch control with a single synchronous state machine whose `mag_on` output feeds the magnetron driver directly.

## Interface

Parameters:
- `CLK_PER_SEC`, default 50_000_000: clock cycles per countdown second. Must be ≥2. Prescaler width is `$clog2(CLK_PER_SEC)`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe: `key_digit` is valid.
- `key_digit`  in  4  BCD digit from keypad; values >9 are ignored.
- `startn`  in  1  start button, active-low level.
- `stopn`  in  1  stop/pause button, active-low level.
- `clearn`  in  1  clear button, active-low level.
- `door_closed`  in  1  1 = door closed.
- `mag_on`  out  1  magnetron enable.
- `timer_done`  out  1  one-cycle pulse when the countdown reaches 0000.
- `done`  out  1  level, high while in DONE.
- `state`  out  2  IDLE=0, COOKING=1, PAUSED=2, DONE=3.
- `min_t`, `min_o`, `sec_t`, `sec_o`  out  4 each  current BCD time digits.

## Operation

- Button events are falling edges. Each button's previous level is registered, and the event is `prev & ~now`. Prev registers reset to 1, so a button held through reset gives no event.
- Event priority within a cycle: clear > stop > start.
- IDLE:
  - A `key_valid` with a digit ≤9 shifts the time left: {min_t,min_o,sec_t,sec_o} ← {min_o,sec_t,sec_o,digit}. The oldest digit is discarded.
  - Start with `door_closed`=1 and time ≠0000 → COOKING, and the prescaler is cleared.
  - Start with the door open or time 0000 is ignored.
  - Stop or clear zeroes the time.
- COOKING:
  - The prescaler counts 0…CLK_PER_SEC-1. At terminal count it wraps to 0 and the time decrements once.
  - Decrement rules:
    - If sec_o>0: sec_o−1.
    - Else if sec_t>0: sec_t−1, sec_o=9.
    - Else: borrow a minute (min_o−1, or min_t−1 with min_o=9), then sec_t=5, sec_o=9.
  - Entered seconds ≥60 (e.g. 0090) are legal and count down as-is.
  - A decrement that produces 0000 → DONE.
  - Door open (`door_closed`=0) → PAUSED in the next cycle. Time and prescaler are held.
  - Stop → PAUSED, time held.
  - Clear → IDLE, time zeroed.
  - Keys are ignored.
- PAUSED:
  - Start with `door_closed`=1 → COOKING. The prescaler is kept, so a partial second resumes where it stopped.
  - Stop or clear → IDLE, time zeroed.
  - Keys are ignored.
- DONE:
  - Time stays 0000.
  - Clear, stop, or door open → IDLE.
  - Start and keys are ignored.
- `mag_on` = (state==COOKING) & `door_closed`. It is combinational on the door input, so the magnetron drops in the same cycle the door opens.
- `done` = (state==DONE).
- `timer_done` is high only in the first cycle of DONE.

## Timing

- Reset values: state IDLE, all digits 0, prescaler 0, `mag_on`=0, `timer_done`=0, `done`=0.
- Reset mid-cook: `mag_on` is low in the cycle after the reset edge.
- Key-to-digit latency: 1 cycle. A digit sampled at edge N is visible after edge N.
- Start to cooking: the start event at edge N gives state=COOKING and `mag_on`=1 after edge N.
- First decrement: CLK_PER_SEC cycles after entering COOKING from IDLE.
- Time 0001 → 0000:
  - The terminal prescaler cycle at edge N gives time 0000, state DONE, `timer_done`=1 and `mag_on`=0 after edge N.
  - `timer_done` returns to 0 after edge N+1.
- Door opening at terminal count: the pause wins. No decrement occurs and the state goes to PAUSED.
- Clear and start in the same cycle: clear wins (IDLE, time 0000).

## Test plan

Use CLK_PER_SEC=4 for all scenarios.

1. Reset, then keys 1,2,3,4,5 → digits read 2,3,4,5 (time 23:45). Key value 0xA → unchanged.
2. Keys 0,0,0,3, start, door closed → `mag_on`=1 next cycle. Time shows 0002 after 4 cycles and 0000 after 12 cycles, with `timer_done` pulsed exactly 1 cycle, `done`=1 and `mag_on`=0.
3. Time 0100, cook 4 cycles → time 0059. Time 1000 decrements → 0959.
4. Cooking 0005:
   - Door opens at cycle 2 → `mag_on`=0 in the same cycle, state PAUSED, time held.
   - Door closes, no start → stays PAUSED.
   - Start → resumes, and the next decrement comes 2 cycles later.
5. Cooking: stop → PAUSED. A second stop → IDLE with time 0000. Start in IDLE at 0000 → stays IDLE.
6. In DONE, start is ignored and clear → IDLE. Clear and start in the same cycle → IDLE, 0000. Reset asserted while COOKING → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/cook_sequencer.sv
// Microwave cook controller: BCD keypad entry, MM:SS countdown and
// magnetron gating through a single synchronous state machine.
module cook_sequencer #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic       mag_on,
    output logic       timer_done,
    output logic       done,
    output logic [1:0] state,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o
);

    localparam int PW = $clog2(CLK_PER_SEC);
    localparam logic [PW-1:0] TC = PW'(CLK_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COOKING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        cur, nxt;
    logic [15:0]   tm, tm_n, tm_dec;
    logic [PW-1:0] presc, presc_n;
    logic          td_q, td_n;
    logic          start_q, stop_q, clear_q;
    logic          ev_start, ev_stop, ev_clear;

    assign ev_start = start_q & ~startn;
    assign ev_stop  = stop_q & ~stopn;
    assign ev_clear = clear_q & ~clearn;

    // One-second borrow chain over the four BCD digits
    always_comb begin
        tm_dec = tm;
        if (tm[3:0] != 4'd0) begin
            tm_dec[3:0] = tm[3:0] - 4'd1;
        end else if (tm[7:4] != 4'd0) begin
            tm_dec[7:4] = tm[7:4] - 4'd1;
            tm_dec[3:0] = 4'd9;
        end else if (tm[11:8] != 4'd0) begin
            tm_dec[11:8] = tm[11:8] - 4'd1;
            tm_dec[7:4]  = 4'd5;
            tm_dec[3:0]  = 4'd9;
        end else begin
            tm_dec[15:12] = tm[15:12] - 4'd1;
            tm_dec[11:8]  = 4'd9;
            tm_dec[7:4]   = 4'd5;
            tm_dec[3:0]   = 4'd9;
        end
    end

    always_comb begin
        nxt     = cur;
        tm_n    = tm;
        presc_n = presc;
        unique case (cur)
            IDLE: begin
                if (ev_clear || ev_stop) begin
                    tm_n = 16'd0;
                end else if (ev_start && door_closed && tm != 16'd0) begin
                    nxt     = COOKING;
                    presc_n = '0;
                end else if (key_valid && key_digit <= 4'd9) begin
                    tm_n = {tm[11:0], key_digit};
                end
            end
            COOKING: begin
                // An open door outranks the terminal count
                if (ev_clear) begin
                    nxt  = IDLE;
                    tm_n = 16'd0;
                end else if (ev_stop || !door_closed) begin
                    nxt = PAUSED;
                end else if (presc == TC) begin
                    presc_n = '0;
                    tm_n    = tm_dec;
                    if (tm_dec == 16'd0) nxt = DONE;
                end else begin
                    presc_n = presc + 1'b1;
                end
            end
            PAUSED: begin
                if (ev_clear || ev_stop) begin
                    nxt  = IDLE;
                    tm_n = 16'd0;
                end else if (ev_start && door_closed) begin
                    nxt = COOKING;
                end
            end
            DONE: begin
                tm_n = 16'd0;
                if (ev_clear || ev_stop || !door_closed) nxt = IDLE;
            end
        endcase
        td_n = (cur == COOKING) && (nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= IDLE;
            tm      <= 16'd0;
            presc   <= '0;
            td_q    <= 1'b0;
            start_q <= 1'b1;
            stop_q  <= 1'b1;
            clear_q <= 1'b1;
        end else begin
            cur     <= nxt;
            tm      <= tm_n;
            presc   <= presc_n;
            td_q    <= td_n;
            start_q <= startn;
            stop_q  <= stopn;
            clear_q <= clearn;
        end
    end

    assign mag_on     = (cur == COOKING) & door_closed;
    assign done       = (cur == DONE);
    assign timer_done = td_q;
    assign state      = cur;
    assign min_t      = tm[15:12];
    assign min_o      = tm[11:8];
    assign sec_t      = tm[7:4];
    assign sec_o      = tm[3:0];

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer with CLK_PER_SEC=4.
module tb_cook_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       startn, stopn, clearn, door_closed;
    logic       mag_on, timer_done, done;
    logic [1:0] state;
    logic [3:0] min_t, min_o, sec_t, sec_o;

    int ncmp = 0;
    int nfail = 0;

    cook_sequencer #(.CLK_PER_SEC(4)) dut (
        .clk(clk), .reset(reset),
        .key_valid(key_valid), .key_digit(key_digit),
        .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed),
        .mag_on(mag_on), .timer_done(timer_done), .done(done),
        .state(state),
        .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] tnow();
        return {min_t, min_o, sec_t, sec_o};
    endfunction

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic press_start();
        startn = 1'b0;
        tick();
        startn = 1'b1;
    endtask

    task automatic press_stop();
        stopn = 1'b0;
        tick();
        stopn = 1'b1;
    endtask

    task automatic press_clear();
        clearn = 1'b0;
        tick();
        clearn = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        key_valid = 1'b0;
        key_digit = 4'd0;
        startn = 1'b1;
        stopn = 1'b1;
        clearn = 1'b1;
        door_closed = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_time", tnow(), 16'h0000);
        chk("rst_mag", 16'(mag_on), 16'd0);
        chk("rst_td", 16'(timer_done), 16'd0);
        chk("rst_done", 16'(done), 16'd0);

        // keypad entry and shifting
        key(4'd1);
        chk("key_latency", tnow(), 16'h0001);
        key(4'd2);
        key(4'd3);
        key(4'd4);
        key(4'd5);
        chk("key_shift", tnow(), 16'h2345);
        key(4'hA);
        chk("key_invalid", tnow(), 16'h2345);
        press_clear();
        chk("idle_clear", tnow(), 16'h0000);
        tick();

        // 0003 countdown to DONE
        key(4'd0);
        key(4'd0);
        key(4'd0);
        key(4'd3);
        press_start();
        chk("start_state", 16'(state), 16'd1);
        chk("start_mag", 16'(mag_on), 16'd1);
        repeat (3) tick();
        chk("pre_dec", tnow(), 16'h0003);
        tick();
        chk("dec_4cyc", tnow(), 16'h0002);
        repeat (7) tick();
        chk("dec_11cyc", tnow(), 16'h0001);
        chk("td_early", 16'(timer_done), 16'd0);
        tick();
        chk("done_time", tnow(), 16'h0000);
        chk("done_state", 16'(state), 16'd3);
        chk("done_td", 16'(timer_done), 16'd1);
        chk("done_mag", 16'(mag_on), 16'd0);
        chk("done_lvl", 16'(done), 16'd1);
        tick();
        chk("td_pulse_end", 16'(timer_done), 16'd0);
        chk("done_hold", 16'(done), 16'd1);
        chk("done_time_hold", tnow(), 16'h0000);
        press_clear();
        chk("done_clear", 16'(state), 16'd0);
        tick();

        // minute borrows
        key(4'd1);
        key(4'd0);
        key(4'd0);
        chk("load_0100", tnow(), 16'h0100);
        press_start();
        repeat (4) tick();
        chk("borrow_min", tnow(), 16'h0059);
        press_clear();
        chk("cook_clear_st", 16'(state), 16'd0);
        chk("cook_clear_t", tnow(), 16'h0000);
        tick();
        key(4'd1);
        key(4'd0);
        key(4'd0);
        key(4'd0);
        press_start();
        repeat (4) tick();
        chk("borrow_tens", tnow(), 16'h0959);
        press_clear();
        tick();

        // door open mid-second, resume keeps prescaler
        key(4'd5);
        press_start();
        tick();
        tick();
        door_closed = 1'b0;
        #1;
        chk("door_mag_comb", 16'(mag_on), 16'd0);
        tick();
        chk("door_paused", 16'(state), 16'd2);
        chk("door_hold", tnow(), 16'h0005);
        repeat (3) tick();
        door_closed = 1'b1;
        tick();
        tick();
        chk("close_no_start", 16'(state), 16'd2);
        chk("close_hold", tnow(), 16'h0005);
        press_start();
        chk("resume_state", 16'(state), 16'd1);
        tick();
        chk("resume_1cyc", tnow(), 16'h0005);
        tick();
        chk("resume_2cyc", tnow(), 16'h0004);

        // stop, stop, start at zero
        press_stop();
        chk("stop_paused", 16'(state), 16'd2);
        chk("stop_hold", tnow(), 16'h0004);
        tick();
        press_stop();
        chk("stop2_idle", 16'(state), 16'd0);
        chk("stop2_zero", tnow(), 16'h0000);
        tick();
        press_start();
        chk("start_zero", 16'(state), 16'd0);
        chk("start_zero_mag", 16'(mag_on), 16'd0);
        tick();

        // door opening exactly at terminal count
        key(4'd7);
        press_start();
        repeat (3) tick();
        door_closed = 1'b0;
        tick();
        chk("tc_door_state", 16'(state), 16'd2);
        chk("tc_door_time", tnow(), 16'h0007);
        door_closed = 1'b1;
        press_clear();
        chk("pause_clear", 16'(state), 16'd0);
        chk("pause_clear_t", tnow(), 16'h0000);
        tick();

        // DONE ignores start
        key(4'd1);
        press_start();
        repeat (4) tick();
        chk("d2_state", 16'(state), 16'd3);
        chk("d2_td", 16'(timer_done), 16'd1);
        tick();
        press_start();
        chk("done_ign_start", 16'(state), 16'd3);
        tick();
        press_clear();
        chk("done_clr_idle", 16'(state), 16'd0);
        tick();

        // clear and start together
        key(4'd1);
        clearn = 1'b0;
        startn = 1'b0;
        tick();
        clearn = 1'b1;
        startn = 1'b1;
        chk("clr_start_st", 16'(state), 16'd0);
        chk("clr_start_t", tnow(), 16'h0000);
        tick();

        // reset mid-cook
        key(4'd2);
        press_start();
        tick();
        chk("pre_rst_mag", 16'(mag_on), 16'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_state", 16'(state), 16'd0);
        chk("mid_rst_time", tnow(), 16'h0000);
        chk("mid_rst_mag", 16'(mag_on), 16'd0);
        chk("mid_rst_td", 16'(timer_done), 16'd0);
        chk("mid_rst_done", 16'(done), 16'd0);
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
